// File: rtl/arp_resolver.sv
// arp_resolver: next-hop MAC resolver with a small register-based IP->MAC cache and timed, retried ARP queries.
// Define ARP_RESOLVER_GATEWAY_EN to route off-subnet targets to gateway_ip and detect directed broadcasts.
module arp_resolver #(
    parameter int CACHE_ENTRIES  = 4,
    parameter int TIMEOUT_CYCLES = 1250000,
    parameter int RETRY_COUNT    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_request_valid,
    output logic        arp_request_ready,
    input  logic [31:0] arp_request_ip,
    output logic        arp_response_valid,
    input  logic        arp_response_ready,
    output logic        arp_response_error,
    output logic [47:0] arp_response_mac,
    output logic        tx_query_valid,
    input  logic        tx_query_ready,
    output logic [31:0] tx_query_ip,
    input  logic        rx_update_valid,
    input  logic [31:0] rx_update_ip,
    input  logic [47:0] rx_update_mac,
    input  logic        clear_cache,
    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask,
    output logic        busy
);
    localparam int PW = (CACHE_ENTRIES > 1) ? $clog2(CACHE_ENTRIES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = $clog2(RETRY_COUNT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_QUERY, S_WAIT, S_RESPOND} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_target;
    logic [RW-1:0] r_retry_cnt;
    logic [TW-1:0] r_timer;
    logic          r_resp_valid;
    logic          r_resp_err;
    logic [47:0]   r_resp_mac;
    logic          r_query_valid;
    logic [31:0]   r_query_ip;

    logic [31:0]              r_ent_ip  [CACHE_ENTRIES];
    logic [47:0]              r_ent_mac [CACHE_ENTRIES];
    logic [CACHE_ENTRIES-1:0] r_ent_valid;
    logic [PW-1:0]            r_repl_ptr;

    logic          w_req_bcast;
    logic          w_upd_bcast;
    logic [31:0]   w_req_target;
    logic          w_lkp_hit;
    logic [47:0]   w_lkp_mac;
    logic          w_upd_hit;
    logic [PW-1:0] w_upd_idx;
    logic          w_upd_ok;
    logic          w_rx_match;

`ifdef ARP_RESOLVER_GATEWAY_EN
    assign w_req_bcast  = (arp_request_ip == '1) || (arp_request_ip == (local_ip | ~subnet_mask));
    assign w_upd_bcast  = (rx_update_ip == '1) || (rx_update_ip == (local_ip | ~subnet_mask));
    assign w_req_target = ((arp_request_ip & subnet_mask) != (local_ip & subnet_mask)) ? gateway_ip
                                                                                      : arp_request_ip;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{local_ip, gateway_ip, subnet_mask};
    assign w_req_bcast  = (arp_request_ip == '1);
    assign w_upd_bcast  = (rx_update_ip == '1);
    assign w_req_target = arp_request_ip;
`endif

    assign w_upd_ok   = rx_update_valid && (rx_update_ip != '0) && !w_upd_bcast;
    assign w_rx_match = rx_update_valid && (rx_update_ip == r_target);

    // Lookup and update matching both use the registered cache contents.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        w_lkp_hit = 1'b0;
        w_lkp_mac = '0;
        w_upd_hit = 1'b0;
        w_upd_idx = '0;
        for (int i = 0; i < CACHE_ENTRIES; i++) begin
            if (r_ent_valid[i] && (r_ent_ip[i] == r_target)) begin
                w_lkp_hit = 1'b1;
                w_lkp_mac = r_ent_mac[i];
            end
            if (r_ent_valid[i] && (r_ent_ip[i] == rx_update_ip)) begin
                w_upd_hit = 1'b1;
                w_upd_idx = PW'(i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (arp_request_valid) w_state_next = w_req_bcast ? S_RESPOND : S_LOOKUP;
            S_LOOKUP:  w_state_next = w_lkp_hit ? S_RESPOND : S_QUERY;
            S_QUERY:   if (tx_query_ready) w_state_next = S_WAIT;
            S_WAIT: begin
                if (w_rx_match)          w_state_next = S_RESPOND;
                else if (r_timer == '0)  w_state_next = (r_retry_cnt != '0) ? S_QUERY : S_RESPOND;
            end
            S_RESPOND: if (arp_response_ready) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target      <= '0;
            r_retry_cnt   <= '0;
            r_timer       <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_err    <= 1'b0;
            r_resp_mac    <= '0;
            r_query_valid <= 1'b0;
            r_query_ip    <= '0;
        end else begin
            r_resp_valid  <= (w_state_next == S_RESPOND);
            r_query_valid <= (w_state_next == S_QUERY);
            case (r_state)
                S_IDLE: if (arp_request_valid) begin
                    r_target    <= w_req_target;
                    r_retry_cnt <= RW'(RETRY_COUNT);
                    if (w_req_bcast) begin
                        r_resp_mac <= '1;
                        r_resp_err <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    if (w_lkp_hit) begin
                        r_resp_mac <= w_lkp_mac;
                        r_resp_err <= 1'b0;
                    end else begin
                        r_query_ip <= r_target;
                    end
                end
                S_QUERY: if (tx_query_ready) begin
                    r_timer     <= TW'(TIMEOUT_CYCLES - 1);
                    r_retry_cnt <= r_retry_cnt - RW'(1);
                end
                S_WAIT: begin
                    if (r_timer != '0) r_timer <= r_timer - TW'(1);
                    // A matching reply beats a simultaneous expiry.
                    if (w_rx_match) begin
                        r_resp_mac <= rx_update_mac;
                        r_resp_err <= 1'b0;
                    end else if ((r_timer == '0) && (r_retry_cnt == '0)) begin
                        r_resp_mac <= '0;
                        r_resp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ent_valid <= '0;
            r_repl_ptr  <= '0;
        end else if (clear_cache) begin
            r_ent_valid <= '0;
            r_repl_ptr  <= '0;
        end else if (w_upd_ok && !w_upd_hit) begin
            r_ent_valid[r_repl_ptr] <= 1'b1;
            r_repl_ptr              <= r_repl_ptr + PW'(1);
        end
    end

    // NOTE: entry payloads need no reset; the valid bits alone decide whether an entry is visible.
    always_ff @(posedge clk) begin
        if (w_upd_ok && !clear_cache) begin
            if (w_upd_hit) begin
                r_ent_mac[w_upd_idx] <= rx_update_mac;
            end else begin
                r_ent_ip[r_repl_ptr]  <= rx_update_ip;
                r_ent_mac[r_repl_ptr] <= rx_update_mac;
            end
        end
    end

    assign arp_request_ready  = (r_state == S_IDLE);
    assign busy               = (r_state != S_IDLE);
    assign arp_response_valid = r_resp_valid;
    assign arp_response_error = r_resp_err;
    assign arp_response_mac   = r_resp_mac;
    assign tx_query_valid     = r_query_valid;
    assign tx_query_ip        = r_query_ip;
endmodule

// File: tb/tb_arp_resolver.sv
// tb_arp_resolver: table-driven directed checks of arp_resolver (cache, routing, timeout, broadcast)
// plus hand-written backpressure and mid-operation reset sequences.
module tb_arp_resolver;
    localparam int TO  = 8;
    localparam int RET = 3;
    localparam int NV  = 13;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arp_request_valid;
    logic        arp_request_ready;
    logic [31:0] arp_request_ip;
    logic        arp_response_valid;
    logic        arp_response_ready;
    logic        arp_response_error;
    logic [47:0] arp_response_mac;
    logic        tx_query_valid;
    logic        tx_query_ready;
    logic [31:0] tx_query_ip;
    logic        rx_update_valid;
    logic [31:0] rx_update_ip;
    logic [47:0] rx_update_mac;
    logic        clear_cache;
    logic [31:0] local_ip;
    logic [31:0] gateway_ip;
    logic [31:0] subnet_mask;
    logic        busy;

    arp_resolver #(
        .CACHE_ENTRIES (4),
        .TIMEOUT_CYCLES(TO),
        .RETRY_COUNT   (RET)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .arp_request_valid (arp_request_valid),
        .arp_request_ready (arp_request_ready),
        .arp_request_ip    (arp_request_ip),
        .arp_response_valid(arp_response_valid),
        .arp_response_ready(arp_response_ready),
        .arp_response_error(arp_response_error),
        .arp_response_mac  (arp_response_mac),
        .tx_query_valid    (tx_query_valid),
        .tx_query_ready    (tx_query_ready),
        .tx_query_ip       (tx_query_ip),
        .rx_update_valid   (rx_update_valid),
        .rx_update_ip      (rx_update_ip),
        .rx_update_mac     (rx_update_mac),
        .clear_cache       (clear_cache),
        .local_ip          (local_ip),
        .gateway_ip        (gateway_ip),
        .subnet_mask       (subnet_mask),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ip;
        bit          reply;
        logic [47:0] rmac;
        int          qlat;   // sample of first query after accept, 0 = no query
        int          rlat;   // sample of response after accept
        int          nq;
        logic [31:0] qip;
        logic [47:0] mac;
        bit          err;
    } vec_t;

    vec_t vecs[NV];
    int   g_qt[4];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one request and follows it to the response, optionally replying to the first query.
    task automatic transact(input logic [31:0] ip, input bit reply, input logic [47:0] rmac,
                            output int qlat, output int rlat, output int nq, output logic [31:0] qip,
                            output logic [47:0] mac, output logic err, output bit got);
        int inj;
        qlat = 0; rlat = 0; nq = 0; qip = '0; mac = '0; err = 1'b0; got = 1'b0; inj = -1;
        for (int k = 0; k < 4; k++) g_qt[k] = 0;
        for (int w = 0; w < 50 && !arp_request_ready; w++) @(negedge clk);
        arp_request_valid = 1'b1;
        arp_request_ip    = ip;
        @(negedge clk);
        arp_request_valid = 1'b0;
        for (int c = 1; c <= 200 && !got; c++) begin
            rx_update_valid = 1'b0;
            if (inj == c) begin
                rx_update_valid = 1'b1;
                rx_update_ip    = qip;
                rx_update_mac   = rmac;
            end
            if (arp_response_valid) begin
                got  = 1'b1;
                rlat = c;
                mac  = arp_response_mac;
                err  = arp_response_error;
            end else if (tx_query_valid) begin
                if (nq == 0) begin
                    qlat = c;
                    qip  = tx_query_ip;
                    if (reply) inj = c + 1;
                end
                if (nq < 4) g_qt[nq] = c;
                nq++;
            end
            @(negedge clk);
        end
        rx_update_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        int          qlat, rlat, nq;
        logic [31:0] qip;
        logic [47:0] mac;
        logic        err;
        bit          got;
        transact(vecs[idx].ip, vecs[idx].reply, vecs[idx].rmac, qlat, rlat, nq, qip, mac, err, got);
        check($sformatf("v%0d_resp_seen", idx), 64'(got), 64'(1));
        check($sformatf("v%0d_query_lat", idx), 64'(qlat), 64'(vecs[idx].qlat));
        check($sformatf("v%0d_resp_lat", idx), 64'(rlat), 64'(vecs[idx].rlat));
        check($sformatf("v%0d_num_queries", idx), 64'(nq), 64'(vecs[idx].nq));
        if (vecs[idx].nq > 0) check($sformatf("v%0d_query_ip", idx), 64'(qip), 64'(vecs[idx].qip));
        check($sformatf("v%0d_mac", idx), 64'(mac), 64'(vecs[idx].mac));
        check($sformatf("v%0d_err", idx), 64'(err), 64'(vecs[idx].err));
        for (int k = 1; k < nq && k < 4; k++)
            check($sformatf("v%0d_query_spacing%0d", idx, k), 64'(g_qt[k] - g_qt[k-1]), 64'(TO + 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(arp_request_ready), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_resp_valid"}, 64'(arp_response_valid), 64'(0));
        check({tag, "_resp_err"}, 64'(arp_response_error), 64'(0));
        check({tag, "_resp_mac"}, 64'(arp_response_mac), 64'(0));
        check({tag, "_query_valid"}, 64'(tx_query_valid), 64'(0));
        check({tag, "_query_ip"}, 64'(tx_query_ip), 64'(0));
    endtask

    initial begin
        automatic int tmo_rlat = 2 + RET * (TO + 1);
        vecs[0]  = '{32'h0A000005, 1'b1, 48'h020000000005, 2, 4, 1, 32'h0A000005, 48'h020000000005, 1'b0};
        vecs[1]  = '{32'h0A000005, 1'b0, 48'h0, 0, 2, 0, 32'h0, 48'h020000000005, 1'b0};
        vecs[2]  = '{32'hFFFFFFFF, 1'b0, 48'h0, 0, 1, 0, 32'h0, 48'hFFFFFFFFFFFF, 1'b0};
        vecs[3]  = '{32'h0A000006, 1'b0, 48'h0, 2, tmo_rlat, RET, 32'h0A000006, 48'h0, 1'b1};
`ifdef ARP_RESOLVER_GATEWAY_EN
        vecs[4]  = '{32'h08080808, 1'b1, 48'h0200000000FE, 2, 4, 1, 32'h0A0000FE, 48'h0200000000FE, 1'b0};
        vecs[5]  = '{32'h0A0000FF, 1'b1, 48'h0200000000FF, 0, 1, 0, 32'h0, 48'hFFFFFFFFFFFF, 1'b0};
`else
        vecs[4]  = '{32'h08080808, 1'b1, 48'h0200000000FE, 2, 4, 1, 32'h08080808, 48'h0200000000FE, 1'b0};
        vecs[5]  = '{32'h0A0000FF, 1'b1, 48'h0200000000FF, 2, 4, 1, 32'h0A0000FF, 48'h0200000000FF, 1'b0};
`endif
        vecs[6]  = '{32'h0A00000C, 1'b0, 48'h0, 0, 2, 0, 32'h0, 48'h02000000010C, 1'b0};
        vecs[7]  = '{32'h0A00000D, 1'b0, 48'h0, 0, 2, 0, 32'h0, 48'h02000000010D, 1'b0};
        vecs[8]  = '{32'h0A00000E, 1'b0, 48'h0, 0, 2, 0, 32'h0, 48'h02000000010E, 1'b0};
        vecs[9]  = '{32'h0A00000F, 1'b0, 48'h0, 0, 2, 0, 32'h0, 48'h02000000010F, 1'b0};
        vecs[10] = '{32'h0A00000B, 1'b0, 48'h0, 2, tmo_rlat, RET, 32'h0A00000B, 48'h0, 1'b1};
        vecs[11] = '{32'h0A00000C, 1'b0, 48'h0, 2, tmo_rlat, RET, 32'h0A00000C, 48'h0, 1'b1};
        vecs[12] = '{32'h0A000014, 1'b0, 48'h0, 2, tmo_rlat, RET, 32'h0A000014, 48'h0, 1'b1};

        rst_n              = 1'b0;
        arp_request_valid  = 1'b0;
        arp_request_ip     = '0;
        arp_response_ready = 1'b1;
        tx_query_ready     = 1'b1;
        rx_update_valid    = 1'b0;
        rx_update_ip       = '0;
        rx_update_mac      = '0;
        clear_cache        = 1'b0;
        local_ip           = 32'h0A000001;
        gateway_ip         = 32'h0A0000FE;
        subnet_mask        = 32'hFFFFFF00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss, hit, broadcast, timeout, routing, directed broadcast.
        for (int i = 0; i <= 5; i++) run_vec(i);

        // Replacement: five distinct updates into a 4-entry cache evict the first.
        clear_cache = 1'b1;
        @(negedge clk);
        clear_cache = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rx_update_valid = 1'b1;
            rx_update_ip    = 32'h0A00000B + 32'(k);
            rx_update_mac   = 48'h02000000010B + 48'(k);
            @(negedge clk);
        end
        rx_update_valid = 1'b0;
        for (int i = 6; i <= 10; i++) run_vec(i);

        // Clear in the same cycle as an update: nothing is stored.
        clear_cache     = 1'b1;
        rx_update_valid = 1'b1;
        rx_update_ip    = 32'h0A000014;
        rx_update_mac   = 48'h020000000014;
        @(negedge clk);
        clear_cache     = 1'b0;
        rx_update_valid = 1'b0;
        for (int i = 11; i <= 12; i++) run_vec(i);

        // Query backpressure, then response backpressure.
        tx_query_ready    = 1'b0;
        arp_request_valid = 1'b1;
        arp_request_ip    = 32'h0A00001E;
        @(negedge clk);
        arp_request_valid = 1'b0;
        for (int w = 0; w < 10 && !tx_query_valid; w++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp_query_valid%0d", k), 64'(tx_query_valid), 64'(1));
            check($sformatf("bp_query_ip%0d", k), 64'(tx_query_ip), 64'(32'h0A00001E));
            @(negedge clk);
        end
        tx_query_ready = 1'b1;
        @(negedge clk);
        check("bp_wait_busy", 64'(busy), 64'(1));
        check("bp_wait_query_dropped", 64'(tx_query_valid), 64'(0));
        arp_response_ready = 1'b0;
        rx_update_valid    = 1'b1;
        rx_update_ip       = 32'h0A00001E;
        rx_update_mac      = 48'h02000000001E;
        @(negedge clk);
        rx_update_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("bp_resp_valid%0d", k), 64'(arp_response_valid), 64'(1));
            check($sformatf("bp_resp_mac%0d", k), 64'(arp_response_mac), 64'(48'h02000000001E));
            @(negedge clk);
        end
        arp_response_ready = 1'b1;
        @(negedge clk);
        check("b2b_ready_after_resp", 64'(arp_request_ready), 64'(1));
        check("b2b_resp_dropped", 64'(arp_response_valid), 64'(0));

        // Reset while waiting for a reply.
        arp_request_valid = 1'b1;
        arp_request_ip    = 32'h0A00001F;
        @(negedge clk);
        arp_request_valid = 1'b0;
        for (int w = 0; w < 10 && !tx_query_valid; w++) @(negedge clk);
        check("rst_query_ip", 64'(tx_query_ip), 64'(32'h0A00001F));
        @(negedge clk);
        check("rst_wait_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(arp_request_ready), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
